// File: rtl/i2c_slave_2byte_resp.sv
// I2C target for 2-byte VCM transactions: reads return a latched word, writes capture one.
// Optional 2-CLK line stability filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_2byte_resp #(
  parameter logic [6:0] SLAVE_ADDR = 7'h0C
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  input  logic [15:0] TX_DATA,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        BUSY,
  output logic [3:0]  ST
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_TX_BYTE   = 3'd3,
    S_TX_ACKCHK = 3'd4,
    S_RX_BYTE   = 3'd5,
    S_RX_ACK    = 3'd6,
    S_IGNORE    = 3'd7
  } st_t;

  logic [1:0]  r_scl_s;
  logic [1:0]  r_sda_s;
  logic        r_scl_d;
  logic        r_sda_d;
  logic        w_scl;
  logic        w_sda;

  st_t         r_st;
  logic [3:0]  r_bit;
  logic [1:0]  r_byte;
  logic [7:0]  r_sh;
  logic [7:0]  r_b0;
  logic [15:0] r_shadow;
  logic        r_oe;
  logic [15:0] r_rx;
  logic        r_vld;
  logic        r_busy;

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic r_scl_p;
  logic r_sda_p;
  logic r_scl_f;
  logic r_sda_f;

  // level follows the synchronizer only after two equal samples
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scl_p <= 1'b1;
      r_sda_p <= 1'b1;
      r_scl_f <= 1'b1;
      r_sda_f <= 1'b1;
    end else begin
      r_scl_p <= r_scl_s[1];
      r_sda_p <= r_sda_s[1];
      if (r_scl_s[1] == r_scl_p) r_scl_f <= r_scl_p;
      if (r_sda_s[1] == r_sda_p) r_sda_f <= r_sda_p;
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s[1];
  assign w_sda = r_sda_s[1];
`endif

  // idle bus is high, so reset to 1 to avoid a false event
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], SCL_IN};
      r_sda_s <= {r_sda_s[0], SDA_IN};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic       w_hi;
  logic       w_start;
  logic       w_stop;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_txb;
  logic [2:0] w_idx;
  logic       w_tbit;
  logic       w_match;

  assign w_hi    = w_scl & r_scl_d;
  assign w_start = w_hi & r_sda_d & ~w_sda;
  assign w_stop  = w_hi & ~r_sda_d & w_sda;
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;

  assign w_txb   = (r_byte == 2'd0) ? r_shadow[15:8] :
                   (r_byte == 2'd1) ? r_shadow[7:0]  : 8'hFF;
  assign w_idx   = 3'd7 - r_bit[2:0];
  assign w_tbit  = w_txb[w_idx];
  assign w_match = (r_sh[7:1] == SLAVE_ADDR) && (r_sh[7:1] != 7'h00);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_st     <= S_IDLE;
      r_bit    <= 4'd0;
      r_byte   <= 2'd0;
      r_sh     <= 8'h00;
      r_b0     <= 8'h00;
      r_shadow <= 16'h0000;
      r_oe     <= 1'b0;
      r_rx     <= 16'h0000;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_stop) begin
        r_st   <= S_IDLE;
        r_oe   <= 1'b0;
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_st   <= S_ADDR;
        r_bit  <= 4'd0;
        r_byte <= 2'd0;
        r_oe   <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        unique case (r_st)
          S_ADDR: begin
            if (w_rise) begin
              r_sh  <= {r_sh[6:0], w_sda};
              r_bit <= r_bit + 4'd1;
            end else if (w_fall && r_bit == 4'd8) begin
              if (w_match) begin
                r_st     <= S_ADDR_ACK;
                r_oe     <= 1'b1;
                r_shadow <= TX_DATA;
                r_busy   <= 1'b1;
              end else begin
                r_st <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            // r_sh[0] still holds R/W from the address byte
            if (w_fall) begin
              r_bit <= 4'd0;
              if (r_sh[0]) begin
                r_st <= S_TX_BYTE;
                r_oe <= ~r_shadow[15];
              end else begin
                r_st <= S_RX_BYTE;
                r_oe <= 1'b0;
              end
            end
          end
          S_TX_BYTE: begin
            if (w_rise) begin
              r_bit <= r_bit + 4'd1;
            end else if (w_fall) begin
              if (r_bit == 4'd8) begin
                r_oe <= 1'b0;
                r_st <= S_TX_ACKCHK;
              end else begin
                r_oe <= ~w_tbit;
              end
            end
          end
          S_TX_ACKCHK: begin
            if (w_rise) begin
              if (!w_sda) begin
                if (r_byte != 2'd3) r_byte <= r_byte + 2'd1;
                r_bit <= 4'd0;
                r_st  <= S_TX_BYTE;
              end else begin
                r_st <= S_IGNORE;
              end
            end
          end
          S_RX_BYTE: begin
            if (w_rise) begin
              r_sh  <= {r_sh[6:0], w_sda};
              r_bit <= r_bit + 4'd1;
            end else if (w_fall && r_bit == 4'd8) begin
              if (!r_byte[1]) begin
                r_oe <= 1'b1;
                r_st <= S_RX_ACK;
              end else begin
                r_st <= S_IGNORE;
              end
            end
          end
          S_RX_ACK: begin
            if (w_fall) begin
              r_oe <= 1'b0;
              if (r_byte == 2'd0) r_b0 <= r_sh;
              if (r_byte == 2'd1) begin
                r_rx  <= {r_b0, r_sh};
                r_vld <= 1'b1;
              end
              if (r_byte != 2'd3) r_byte <= r_byte + 2'd1;
              r_bit <= 4'd0;
              r_st  <= S_RX_BYTE;
            end
          end
          S_IDLE, S_IGNORE: ;
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  assign SDA_OE   = r_oe;
  assign RX_DATA  = r_rx;
  assign RX_VALID = r_vld;
  assign BUSY     = r_busy;
  assign ST       = {1'b0, r_st};

endmodule

// File: tb/tb_i2c_slave_2byte_resp.sv
// Directed bench for i2c_slave_2byte_resp: bench-side master on a wired-AND SDA.
// Glitch scenario runs only when I2C_SLV_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_2byte_resp;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        SCL_IN;
  logic        m_sda;
  logic        w_sda;
  logic        SDA_OE;
  logic [15:0] TX_DATA;
  logic [15:0] RX_DATA;
  logic        RX_VALID;
  logic        BUSY;
  logic [3:0]  ST;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int oecnt = 0;

  assign w_sda = m_sda & ~SDA_OE;

  i2c_slave_2byte_resp #(.SLAVE_ADDR(7'h0C)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SCL_IN(SCL_IN), .SDA_IN(w_sda),
    .SDA_OE(SDA_OE), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .BUSY(BUSY), .ST(ST)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RX_VALID) vcnt <= vcnt + 1;
    if (SDA_OE) oecnt <= oecnt + 1;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wt(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bit_io(input logic b, output logic s);
    wt(8); m_sda = b; wt(8);
    SCL_IN = 1'b1; wt(12);
    s = w_sda; wt(12);
    SCL_IN = 1'b0;
  endtask

  task automatic byte_io(input logic [7:0] w, input logic ai,
                         output logic [7:0] r, output logic ao);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(w[i], s);
      r[i] = s;
    end
    bit_io(ai, ao);
  endtask

  task automatic start_c();
    wt(8); m_sda = 1'b1; wt(8);
    SCL_IN = 1'b1; wt(16);
    m_sda = 1'b0; wt(16);
    SCL_IN = 1'b0;
  endtask

  task automatic stop_c();
    wt(8); m_sda = 1'b0; wt(8);
    SCL_IN = 1'b1; wt(16);
    m_sda = 1'b1; wt(16);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; SCL_IN = 1'b1; m_sda = 1'b1; TX_DATA = 16'h0000;
    wt(4);
    n_cmp += 5;
    if (SDA_OE !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", SDA_OE); end
    if (RX_DATA !== 16'h0) begin n_bad++; $display("FAIL rst_rx: got %h want 0000", RX_DATA); end
    if (RX_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got %b want 0", RX_VALID); end
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    if (ST !== 4'd0) begin n_bad++; $display("FAIL rst_st: got %0d want 0", ST); end
    RESET_N = 1'b1; wt(8);
  endtask

  task automatic test_read();
    logic [7:0] r; logic a;
    TX_DATA = 16'hA55A;
    start_c();
    byte_io(8'h19, 1'b1, r, a);
    TX_DATA = 16'h0000;
    n_cmp += 2;
    if (a !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    if (BUSY !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b want 1", BUSY); end
    byte_io(8'hFF, 1'b0, r, a);
    n_cmp++;
    if (r !== 8'hA5) begin n_bad++; $display("FAIL rd_b0: got %h want a5", r); end
    byte_io(8'hFF, 1'b1, r, a);
    wt(8);
    n_cmp += 3;
    if (r !== 8'h5A) begin n_bad++; $display("FAIL rd_b1: got %h want 5a", r); end
    if (ST !== 4'd7) begin n_bad++; $display("FAIL rd_nack_st: got %0d want 7", ST); end
    if (BUSY !== 1'b1) begin n_bad++; $display("FAIL rd_busy_hold: got %b want 1", BUSY); end
    stop_c();
    n_cmp += 2;
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rd_stop_busy: got %b want 0", BUSY); end
    if (ST !== 4'd0) begin n_bad++; $display("FAIL rd_stop_st: got %0d want 0", ST); end
  endtask

  task automatic test_write();
    logic [7:0] r; logic a0, a1, a2; int v0;
    v0 = vcnt;
    start_c();
    byte_io(8'h18, 1'b1, r, a0);
    byte_io(8'h12, 1'b1, r, a1);
    byte_io(8'h34, 1'b1, r, a2);
    stop_c();
    wt(4);
    n_cmp += 3;
    if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
    if (RX_DATA !== 16'h1234) begin n_bad++; $display("FAIL wr_data: got %h want 1234", RX_DATA); end
    if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL wr_pulses: got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_mismatch();
    logic [7:0] r; logic a; int o0;
    o0 = oecnt;
    start_c();
    byte_io(8'h1A, 1'b1, r, a);
    wt(8);
    n_cmp += 3;
    if (a !== 1'b1) begin n_bad++; $display("FAIL mm_ack: got %b want 1", a); end
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mm_busy: got %b want 0", BUSY); end
    if (ST !== 4'd7) begin n_bad++; $display("FAIL mm_st: got %0d want 7", ST); end
    byte_io(8'hFF, 1'b1, r, a);
    stop_c();
    n_cmp += 3;
    if (r !== 8'hFF) begin n_bad++; $display("FAIL mm_data: got %h want ff", r); end
    if (oecnt - o0 !== 0) begin n_bad++; $display("FAIL mm_oe: got %0d want 0", oecnt - o0); end
    if (ST !== 4'd0) begin n_bad++; $display("FAIL mm_stop_st: got %0d want 0", ST); end
  endtask

  task automatic test_read3();
    logic [7:0] r0, r1, r2; logic a;
    TX_DATA = 16'h1357;
    start_c();
    byte_io(8'h19, 1'b1, r0, a);
    byte_io(8'hFF, 1'b0, r0, a);
    byte_io(8'hFF, 1'b0, r1, a);
    byte_io(8'hFF, 1'b1, r2, a);
    stop_c();
    n_cmp++;
    if ({r0, r1, r2} !== 24'h1357FF) begin n_bad++; $display("FAIL rd3: got %h want 1357ff", {r0, r1, r2}); end
  endtask

  task automatic test_write3();
    logic [7:0] r; logic a0, a1, a2, a3; int v0;
    v0 = vcnt;
    start_c();
    byte_io(8'h18, 1'b1, r, a0);
    byte_io(8'hAB, 1'b1, r, a1);
    byte_io(8'hCD, 1'b1, r, a2);
    byte_io(8'hEF, 1'b1, r, a3);
    stop_c();
    wt(4);
    n_cmp += 3;
    if ({a0, a1, a2, a3} !== 4'b0001) begin n_bad++; $display("FAIL wr3_acks: got %b want 0001", {a0, a1, a2, a3}); end
    if (RX_DATA !== 16'hABCD) begin n_bad++; $display("FAIL wr3_data: got %h want abcd", RX_DATA); end
    if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL wr3_pulses: got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1; logic a0, a1, a2; int v0;
    v0 = vcnt;
    TX_DATA = 16'hBEEF;
    start_c();
    byte_io(8'h18, 1'b1, r0, a0);
    byte_io(8'h77, 1'b1, r0, a1);
    start_c();
    wt(8);
    n_cmp++;
    if (ST !== 4'd1) begin n_bad++; $display("FAIL rs_st: got %0d want 1", ST); end
    byte_io(8'h19, 1'b1, r0, a2);
    byte_io(8'hFF, 1'b0, r0, a0);
    byte_io(8'hFF, 1'b1, r1, a0);
    stop_c();
    wt(4);
    n_cmp += 4;
    if ({a1, a2} !== 2'b00) begin n_bad++; $display("FAIL rs_acks: got %b want 00", {a1, a2}); end
    if ({r0, r1} !== 16'hBEEF) begin n_bad++; $display("FAIL rs_rdata: got %h want beef", {r0, r1}); end
    if (RX_DATA !== 16'hABCD) begin n_bad++; $display("FAIL rs_rx: got %h want abcd", RX_DATA); end
    if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL rs_pulses: got %0d want 0", vcnt - v0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic a;
    TX_DATA = 16'h0000;
    start_c();
    byte_io(8'h19, 1'b1, r, a);
    m_sda = 1'b1;
    wt(10);
    n_cmp += 2;
    if (SDA_OE !== 1'b1) begin n_bad++; $display("FAIL rm_oe_pre: got %b want 1", SDA_OE); end
    if (ST !== 4'd3) begin n_bad++; $display("FAIL rm_st_pre: got %0d want 3", ST); end
    RESET_N = 1'b0;
    #1;
    n_cmp += 4;
    if (SDA_OE !== 1'b0) begin n_bad++; $display("FAIL rm_oe: got %b want 0", SDA_OE); end
    if (ST !== 4'd0) begin n_bad++; $display("FAIL rm_st: got %0d want 0", ST); end
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", BUSY); end
    if (RX_DATA !== 16'h0) begin n_bad++; $display("FAIL rm_rx: got %h want 0000", RX_DATA); end
    wt(3);
    RESET_N = 1'b1;
    stop_c();
  endtask

`ifdef I2C_SLV_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [7:0] w; logic s, a;
    start_c();
    byte_io(8'h18, 1'b1, w, a);
    w = 8'h5C;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        wt(4); SCL_IN = 1'b1; wt(1); SCL_IN = 1'b0;
      end
      bit_io(w[i], s);
    end
    bit_io(1'b1, a);
    byte_io(8'h3E, 1'b1, w, a);
    stop_c();
    wt(4);
    n_cmp++;
    if (RX_DATA !== 16'h5C3E) begin n_bad++; $display("FAIL glitch_rx: got %h want 5c3e", RX_DATA); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_mismatch();
    test_read3();
    test_write3();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_SLV_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
